// File: rtl/xfft_frame_monitor.sv
// xfft_frame_monitor: registers the xfft_0 master AXI-Stream output and
// tracks each beat's position within its frame. It checks tlast placement and
// the tuser bin index against an internal counter, keeps sticky error flags,
// and produces a one-shot trigger pulse aligned to the first beat of a chosen
// frame. Every output feeds datacapture as a captured signal.
module xfft_frame_monitor #(
    parameter int FRAME_LEN  = 64,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clk_enable,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    input  logic [IDX_WIDTH-1:0]  s_tuser,
    input  logic                  trig_arm,
    input  logic [CNT_WIDTH-1:0]  trig_frame,
    input  logic                  clear_errors,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    output logic [IDX_WIDTH-1:0]  m_index,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic                  trig_out,
    output logic                  err_early_tlast,
    output logic                  err_missing_tlast,
    output logic                  err_index,
    output logic                  armed
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_LEN - 1);

    // Error flag bit positions inside the packed error vector.
    localparam int ERR_EARLY   = 0;
    localparam int ERR_MISSING = 1;
    localparam int ERR_INDEX   = 2;
    localparam int NUM_ERR     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } trig_state_t;

    trig_state_t state_reg, state_next;

    logic [DATA_WIDTH-1:0] m_tdata_reg;
    logic                  m_tvalid_reg;
    logic                  m_tlast_reg;
    logic [IDX_WIDTH-1:0]  m_index_reg;
    logic                  frame_done_reg;
    logic [CNT_WIDTH-1:0]  frame_count_reg;
    logic                  trig_out_reg;
    logic                  trig_arm_reg;
    logic [IDX_WIDTH-1:0]  idx_reg, idx_next;
    logic [NUM_ERR-1:0]    err_reg, err_next, err_set;

    logic accept;
    logic at_last;
    logic frame_end;
    logic arm_rise;
    logic trig_fire;

    assign accept  = clk_enable & s_tvalid;
    assign at_last = (idx_reg == LAST_IDX);
    // A frame ends on tlast or when the counter reaches the last bin, so a
    // coincident tlast at the last bin still counts as one frame.
    assign frame_end = s_tvalid & (s_tlast | at_last);
    assign arm_rise  = trig_arm & ~trig_arm_reg;

    // Beat counter advance: wrap on frame end, otherwise step by one.
    always_comb begin
        idx_next = idx_reg + 1'b1;
        if (frame_end) begin
            idx_next = '0;
        end
    end

    // Per-beat error detection against the internal counter.
    always_comb begin
        err_set              = '0;
        err_set[ERR_EARLY]   = s_tvalid & s_tlast & (idx_reg < LAST_IDX);
        err_set[ERR_MISSING] = s_tvalid & at_last & ~s_tlast;
        err_set[ERR_INDEX]   = s_tvalid & (s_tuser != idx_reg);
    end

    // Sticky flags: a new error wins over a simultaneous clear.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ERR; gi++) begin : g_err
            assign err_next[gi] = (err_reg[gi] & ~clear_errors) | err_set[gi];
        end
    endgenerate

    // Trigger FSM next state; disarm takes priority over a fire in ARMED.
    always_comb begin
        state_next = state_reg;
        trig_fire  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (arm_rise) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!trig_arm) begin
                    state_next = ST_IDLE;
                end else if (accept && (idx_reg == '0) &&
                             (frame_count_reg == trig_frame)) begin
                    state_next = ST_FIRED;
                    trig_fire  = 1'b1;
                end
            end
            ST_FIRED: begin
                if (!trig_arm) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Trigger state and arm edge register; both freeze while clk_enable is low.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            trig_arm_reg <= 1'b0;
        end else if (clk_enable) begin
            state_reg    <= state_next;
            trig_arm_reg <= trig_arm;
        end
    end

    // Output register stage, beat counter, frame counter and sticky errors.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_tdata_reg     <= '0;
            m_tvalid_reg    <= 1'b0;
            m_tlast_reg     <= 1'b0;
            m_index_reg     <= '0;
            frame_done_reg  <= 1'b0;
            frame_count_reg <= '0;
            trig_out_reg    <= 1'b0;
            idx_reg         <= '0;
            err_reg         <= '0;
        end else if (clk_enable) begin
            m_tvalid_reg   <= s_tvalid;
            frame_done_reg <= frame_end;
            trig_out_reg   <= trig_fire;
            err_reg        <= err_next;
            if (s_tvalid) begin
                m_tdata_reg <= s_tdata;
                m_tlast_reg <= s_tlast;
                m_index_reg <= idx_reg;
                idx_reg     <= idx_next;
                if (frame_end) begin
                    frame_count_reg <= frame_count_reg + 1'b1;
                end
            end else begin
                m_tlast_reg <= 1'b0;
            end
        end
    end

    assign m_tdata           = m_tdata_reg;
    assign m_tvalid          = m_tvalid_reg;
    assign m_tlast           = m_tlast_reg;
    assign m_index           = m_index_reg;
    assign frame_done        = frame_done_reg;
    assign frame_count       = frame_count_reg;
    assign trig_out          = trig_out_reg;
    assign err_early_tlast   = err_reg[ERR_EARLY];
    assign err_missing_tlast = err_reg[ERR_MISSING];
    assign err_index         = err_reg[ERR_INDEX];
    assign armed             = (state_reg == ST_ARMED);

endmodule

// File: tb/tb_xfft_frame_monitor.sv
// Testbench for xfft_frame_monitor with FRAME_LEN=8: a behavioural model feeds
// a scoreboard queue per driven cycle, a table of hand-computed vectors covers
// the tlast/index error cases, and short sequences cover trigger, stall and reset.
module tb_xfft_frame_monitor;

    localparam int FL = 8;
    localparam int DW = 16;
    localparam int IW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clk_enable = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic [IW-1:0] s_tuser = '0;
    logic          trig_arm = 1'b0;
    logic [CW-1:0] trig_frame = '0;
    logic          clear_errors = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic [IW-1:0] m_index;
    logic          frame_done;
    logic [CW-1:0] frame_count;
    logic          trig_out;
    logic          err_early_tlast;
    logic          err_missing_tlast;
    logic          err_index;
    logic          armed;

    xfft_frame_monitor #(
        .FRAME_LEN (FL),
        .DATA_WIDTH(DW),
        .IDX_WIDTH (IW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .clk_enable       (clk_enable),
        .s_tdata          (s_tdata),
        .s_tvalid         (s_tvalid),
        .s_tlast          (s_tlast),
        .s_tuser          (s_tuser),
        .trig_arm         (trig_arm),
        .trig_frame       (trig_frame),
        .clear_errors     (clear_errors),
        .m_tdata          (m_tdata),
        .m_tvalid         (m_tvalid),
        .m_tlast          (m_tlast),
        .m_index          (m_index),
        .frame_done       (frame_done),
        .frame_count      (frame_count),
        .trig_out         (trig_out),
        .err_early_tlast  (err_early_tlast),
        .err_missing_tlast(err_missing_tlast),
        .err_index        (err_index),
        .armed            (armed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [DW-1:0] tdata;
        logic          tlast;
        logic [IW-1:0] index;
        logic          done;
        logic          trig;
        logic [CW-1:0] fc;
        logic [2:0]    errs;   // {index, missing, early}
        logic          armed;
    } exp_t;

    typedef struct {
        logic          v;
        logic          l;
        logic [IW-1:0] u;
        logic          clr;
        logic [IW-1:0] ei;
        logic          ed;
        logic [2:0]    ee;
    } vec_t;

    exp_t cur;
    exp_t sb[$];
    vec_t tbl[$];

    int   md_idx;
    int   md_st;      // 0 idle, 1 armed, 2 fired
    logic md_armq;

    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;
    int trig_cnt = 0;
    logic [IW-1:0] trig_idx;
    logic [CW-1:0] trig_fc_at;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc_n, act, exp);
        end
    endtask

    task automatic model_step(input logic en, input logic v, input logic [DW-1:0] d,
                              input logic l, input logic [IW-1:0] u, input logic clr,
                              input logic arm);
        logic       rise;
        logic       endf;
        logic       fire;
        logic [2:0] ns;
        int         nst;
        if (!en) return;
        rise    = arm & ~md_armq;
        md_armq = arm;
        endf    = v & (l | (md_idx == FL - 1));
        ns[0]   = v & l & (md_idx < FL - 1);
        ns[1]   = v & (md_idx == FL - 1) & ~l;
        ns[2]   = v & (int'(u) != md_idx);
        fire    = 1'b0;
        nst     = md_st;
        if (md_st == 0) begin
            if (rise) nst = 1;
        end else if (md_st == 1) begin
            if (!arm) nst = 0;
            else if (v && md_idx == 0 && cur.fc == trig_frame) begin
                nst  = 2;
                fire = 1'b1;
            end
        end else if (!arm) begin
            nst = 0;
        end
        md_st     = nst;
        cur.valid = v;
        cur.done  = endf;
        cur.trig  = fire;
        cur.armed = (nst == 1);
        if (v) begin
            cur.tdata = d;
            cur.tlast = l;
            cur.index = IW'(md_idx);
        end else begin
            cur.tlast = 1'b0;
        end
        cur.errs = (cur.errs & ~{3{clr}}) | ns;
        if (endf) begin
            md_idx = 0;
            cur.fc = cur.fc + 1'b1;
        end else if (v) begin
            md_idx++;
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("m_tvalid", m_tvalid, e.valid);
        chk("m_tdata", m_tdata, e.tdata);
        if (e.valid) begin
            chk("m_tlast", m_tlast, e.tlast);
            chk("m_index", m_index, e.index);
        end
        chk("frame_done", frame_done, e.done);
        chk("trig_out", trig_out, e.trig);
        chk("frame_count", frame_count, e.fc);
        chk("errs", {err_index, err_missing_tlast, err_early_tlast}, e.errs);
        chk("armed", armed, e.armed);
        if (trig_out === 1'b1) begin
            trig_cnt++;
            trig_idx   = m_index;
            trig_fc_at = frame_count;
        end
    endtask

    task automatic cyc(input logic en, input logic v, input logic [DW-1:0] d, input logic l,
                       input logic [IW-1:0] u, input logic clr, input logic arm);
        clk_enable   = en;
        s_tvalid     = v;
        s_tdata      = d;
        s_tlast      = l;
        s_tuser      = u;
        clear_errors = clr;
        trig_arm     = arm;
        model_step(en, v, d, l, u, clr, arm);
        sb.push_back(cur);
        @(posedge clk);
        #1;
        cyc_n++;
        check_out();
    endtask

    task automatic beat(input int u, input logic l, input logic arm);
        cyc(1'b1, 1'b1, DW'($urandom()), l, IW'(u), 1'b0, arm);
    endtask

    // Reset is applied with clk_enable low to show it does not depend on it.
    task automatic do_reset();
        rstn       = 1'b0;
        clk_enable = 1'b0;
        s_tvalid   = 1'b1;
        cur        = '{default: '0};
        md_idx     = 0;
        md_st      = 0;
        md_armq    = 1'b0;
        sb.push_back(cur);
        @(posedge clk);
        #1;
        cyc_n++;
        check_out();
        rstn = 1'b1;
    endtask

    function automatic void add(input logic v, input logic l, input int u, input logic clr,
                                input int ei, input logic ed, input logic [2:0] ee);
        vec_t r;
        r.v = v; r.l = l; r.u = IW'(u); r.clr = clr; r.ei = IW'(ei); r.ed = ed; r.ee = ee;
        tbl.push_back(r);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc_n);
        $fatal(1, "timeout");
    end

    initial begin
        // Early tlast, missing tlast, then index mismatch colliding with a clear.
        for (int i = 0; i < 5; i++) add(1, 0, i, 0, i, 0, 3'b000);
        add(1, 1, 5, 0, 5, 1, 3'b001);
        add(1, 0, 0, 0, 0, 0, 3'b001);
        add(0, 0, 0, 1, 0, 0, 3'b000);
        for (int i = 1; i < 7; i++) add(1, 0, i, 0, i, 0, 3'b000);
        add(1, 0, 7, 0, 7, 1, 3'b010);
        add(1, 0, 0, 0, 0, 0, 3'b010);
        add(0, 0, 0, 1, 0, 0, 3'b000);
        add(1, 0, 1, 0, 1, 0, 3'b000);
        add(1, 0, 3, 1, 2, 0, 3'b100);
        add(0, 0, 0, 1, 0, 0, 3'b000);
        for (int i = 3; i < 7; i++) add(1, 0, i, 0, i, 0, 3'b000);
        add(1, 1, 7, 0, 7, 1, 3'b000);

        do_reset();

        // Nominal: three well-formed frames.
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < FL; i++) beat(i, i == FL - 1, 1'b0);
        chk("nom_frame_count", frame_count, 3);
        chk("nom_errs", {err_index, err_missing_tlast, err_early_tlast}, 0);

        foreach (tbl[k]) begin
            cyc(1'b1, tbl[k].v, DW'($urandom()), tbl[k].l, tbl[k].u, tbl[k].clr, 1'b0);
            if (tbl[k].v) chk("tbl_index", m_index, tbl[k].ei);
            chk("tbl_done", frame_done, tbl[k].ed);
            chk("tbl_errs", {err_index, err_missing_tlast, err_early_tlast}, tbl[k].ee);
        end
        chk("tbl_frame_count", frame_count, 6);

        // Trigger at frame 2, armed during frame 0, then re-armed for frame 5.
        do_reset();
        trig_frame = 2;
        trig_cnt   = 0;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < FL; i++) beat(i, i == FL - 1, (f > 0) || (i >= 2));
        chk("trig1_count", trig_cnt, 1);
        chk("trig1_index", trig_idx, 0);
        chk("trig1_frame", trig_fc_at, 2);
        chk("fired_not_armed", armed, 0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        trig_frame = 5;
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        chk("rearmed", armed, 1);
        for (int f = 4; f < 6; f++)
            for (int i = 0; i < FL; i++) beat(i, i == FL - 1, 1'b1);
        chk("trig2_count", trig_cnt, 2);
        chk("trig2_index", trig_idx, 0);
        chk("trig2_frame", trig_fc_at, 5);

        // Stall at idx 4, resume at idx 5, reset at idx 6.
        cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) beat(i, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) begin
            cyc(1'b0, 1'b1, DW'($urandom()), 1'b1, IW'(9), 1'b1, 1'b1);
            chk("stall_index", m_index, 4);
            chk("stall_valid", m_tvalid, 1);
        end
        beat(5, 1'b0, 1'b0);
        chk("resume_index", m_index, 5);
        do_reset();
        chk("rst_index", m_index, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_armed", armed, 0);
        beat(0, 1'b0, 1'b0);
        chk("post_rst_index", m_index, 0);
        beat(1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/xfft_frame_monitor.md
Name: xfft_frame_monitor

Overview:
- Sits directly upstream of the datacapture block, on the xfft_0 master AXI-Stream output.
- Registers the FFT output stream and tracks the position of each beat within its frame.
- Checks tlast placement and the tuser bin index against its own counter, and keeps sticky error flags.
- Produces a one-shot, frame-aligned trigger pulse and per-beat metadata; all of these are fed to datacapture as captured signals.

Parameters:
- FRAME_LEN, 64, FFT point count (beats per frame), 2..65536.
- DATA_WIDTH, 16, tdata width.
- IDX_WIDTH, 16, width of tuser bin index and internal beat counter; must satisfy 2^IDX_WIDTH >= FRAME_LEN.
- CNT_WIDTH, 16, width of the frame counter.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; synchronous, active-low
- clk_enable  in  1  global clock enable; when low, all state and outputs hold
- s_tdata  in  DATA_WIDTH  xfft m_axis_data_tdata
- s_tvalid  in  1  xfft m_axis_data_tvalid
- s_tlast  in  1  xfft m_axis_data_tlast
- s_tuser  in  IDX_WIDTH  xfft m_axis_data_tuser (XK_INDEX in low bits)
- trig_arm  in  1  arm level; a rising edge arms the trigger
- trig_frame  in  CNT_WIDTH  frame number at which the armed trigger fires
- clear_errors  in  1  clears the sticky error flags
- m_tdata  out  DATA_WIDTH  registered tdata
- m_tvalid  out  1  registered tvalid
- m_tlast  out  1  registered tlast
- m_index  out  IDX_WIDTH  beat position within frame, aligned with m_tdata
- frame_done  out  1  one-cycle pulse on the last beat of a frame (tlast, or forced at FRAME_LEN)
- frame_count  out  CNT_WIDTH  completed-frame count, wraps to 0
- trig_out  out  1  one-cycle trigger pulse, aligned with the first beat of the selected frame
- err_early_tlast  out  1  sticky: tlast seen at index < FRAME_LEN-1
- err_missing_tlast  out  1  sticky: no tlast at index FRAME_LEN-1
- err_index  out  1  sticky: s_tuser != internal index on a valid beat
- armed  out  1  trigger FSM is in ARMED state

Behaviour:
- Reset (rstn=0 at a clk edge) sets every output to 0, the internal index to 0, and the FSM to IDLE. Reset applies regardless of clk_enable and may occur mid-frame; the next valid beat after reset is index 0.
- A beat is accepted when clk_enable=1 and s_tvalid=1. There is no backpressure, so the block always accepts.
- Latency is 1 cycle: m_tdata, m_tvalid, m_tlast, m_index, frame_done and trig_out update on the edge after acceptance.
- With clk_enable=1 and s_tvalid=0: m_tvalid=0 and the pulses are 0; m_tdata holds its last value.
- Index counter:
  - An accepted beat uses the current idx as m_index.
  - Next idx is 0 if (s_tlast or idx==FRAME_LEN-1); otherwise idx+1.
- Frame end: frame_done=1 and frame_count increments (modulo 2^CNT_WIDTH) on any beat that ends a frame per the rule above. Exactly one increment occurs even if tlast and idx==FRAME_LEN-1 coincide.
- Errors are checked on each accepted beat:
  - s_tlast=1 and idx<FRAME_LEN-1 sets err_early_tlast.
  - idx==FRAME_LEN-1 and s_tlast=0 sets err_missing_tlast.
  - s_tuser != idx sets err_index.
  - Flags are sticky until clear_errors=1 (while clk_enable=1). If a clear and a new error occur in the same cycle, the flag ends at 1.
- Trigger FSM, with trig_arm registered for edge detection:
  - IDLE -> ARMED on a trig_arm rising edge.
  - ARMED -> FIRED on an accepted beat with idx==0 and frame_count==trig_frame; trig_out=1 for that beat.
  - FIRED -> IDLE when trig_arm=0.
  - ARMED -> IDLE when trig_arm=0 (disarm before firing).
  - trig_out fires at most once per arm cycle.
  - A trig_arm rising edge in FIRED is ignored; trig_arm must first return low.
- When clk_enable=0, nothing changes: registers, pulses, FSM and the trig_arm edge register all hold. Pulses held high stay high; datacapture samples them only while clk_enable=1.

Test Plan:
- Nominal, FRAME_LEN=8: 3 frames of 8 beats, s_tuser=0..7, tlast on beat 7 -> m_index 0..7 one cycle later; frame_done on beats 7, 15, 23; frame_count=3; all error flags 0.
- Early tlast: tlast on beat index 5 -> err_early_tlast=1, frame_done on that beat, next beat m_index=0, frame_count increments; clear_errors pulse -> flag returns to 0.
- Missing tlast: 8 beats with no tlast -> err_missing_tlast=1, index wraps to 0, frame_done on beat 7.
- Index mismatch plus clear collision: s_tuser=3 at idx 2 in the same cycle clear_errors=1 -> err_index=1 after the edge.
- Trigger: trig_frame=2, trig_arm raised during frame 0 -> trig_out single pulse with m_index=0 of frame 2; no pulse in frame 3 while trig_arm stays high; lower then raise trig_arm with trig_frame=5 -> pulse at frame 5.
- Stall/reset: clk_enable=0 for 4 cycles mid-frame at idx 4 -> outputs frozen, resumes at idx 5; rstn=0 at idx 6 -> all outputs 0, FSM IDLE, next beat m_index=0.
